// File: rtl/adpcm_main_mac_pipe.sv
// Pipelined signed/unsigned multiplier with optional saturating accumulate.
// Operands are widened by one bit so a single signed multiply covers both modes.
module adpcm_main_mac_pipe #(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 32,
  parameter int DOUT_WIDTH = 64,
  parameter int NUM_STAGE  = 2,
  parameter int SAT_EN     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  is_signed,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 2;
  localparam int SW = ((DOUT_WIDTH > PW) ? DOUT_WIDTH : PW) + 1;
  localparam int EW = PW + 3;

  logic signed [DIN0_WIDTH:0] w_opA;
  logic signed [DIN1_WIDTH:0] w_opB;
  logic signed [PW-1:0]       w_prod;
  logic [EW-1:0]              w_inWord;
  logic [EW-1:0]              w_outWord;

  assign w_opA    = {is_signed & din0[DIN0_WIDTH-1], din0};
  assign w_opB    = {is_signed & din1[DIN1_WIDTH-1], din1};
  assign w_prod   = w_opA * w_opB;
  assign w_inWord = {in_valid, acc_en, acc_clr, w_prod};

  // Stage word carries {valid, acc_en, acc_clr, product} between registers.
  generate
    if (NUM_STAGE > 1) begin : g_pipe
      logic [EW-1:0] r_stage [NUM_STAGE-1];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < NUM_STAGE - 1; i++) r_stage[i] <= '0;
        end else if (ce) begin
          r_stage[0] <= w_inWord;
          for (int i = 1; i < NUM_STAGE - 1; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign w_outWord = r_stage[NUM_STAGE-2];
    end else begin : g_direct
      assign w_outWord = w_inWord;
    end
  endgenerate

  logic                     w_stValid;
  logic                     w_stAccEn;
  logic                     w_stAccClr;
  logic signed [PW-1:0]     w_stProd;
  logic signed [SW-1:0]     w_prodExt;
  logic signed [SW-1:0]     w_accExt;
  logic signed [SW-1:0]     w_sum;
  logic [SW-DOUT_WIDTH:0]   w_sumHigh;
  logic                     w_inRange;
  logic [DOUT_WIDTH-1:0]    w_satVal;

  assign w_stValid  = w_outWord[EW-1];
  assign w_stAccEn  = w_outWord[EW-2];
  assign w_stAccClr = w_outWord[EW-3];
  assign w_stProd   = w_outWord[PW-1:0];

  // Full-precision sum: in range only if every bit above the DOUT sign bit matches it.
  assign w_prodExt = {{(SW-PW){w_stProd[PW-1]}}, w_stProd};
  assign w_accExt  = {{(SW-DOUT_WIDTH){dout[DOUT_WIDTH-1]}}, dout};
  assign w_sum     = (w_stAccClr ? '0 : w_accExt) + w_prodExt;
  assign w_sumHigh = w_sum[SW-1:DOUT_WIDTH-1];
  assign w_inRange = (&w_sumHigh) | ~(|w_sumHigh);
  assign w_satVal  = w_sum[SW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DOUT_WIDTH-1){1'b1}}};

  // dout doubles as the accumulator and holds across bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else if (ce) begin
      out_valid <= w_stValid;
      if (w_stValid) begin
        if (!w_stAccEn) begin
          dout <= w_prodExt[DOUT_WIDTH-1:0];
          ovf  <= 1'b0;
        end else if (!w_inRange) begin
          dout <= (SAT_EN != 0) ? w_satVal : w_sum[DOUT_WIDTH-1:0];
          ovf  <= 1'b1;
        end else begin
          dout <= w_sum[DOUT_WIDTH-1:0];
          ovf  <= ovf & ~w_stAccClr;
        end
      end
    end
  end

endmodule
